// File: rtl/irq_pkg.sv
// Shared types and sizes for the eight-input interrupt controller.
package irq_pkg;

    localparam int NREQ = 8;
    localparam int IDW  = 3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        OFFER   = 2'd1,
        SERVICE = 2'd2
    } state_t;

endpackage

// File: rtl/prio_pick8.sv
// Combinational highest-set-bit picker: 8-bit vector in, 3-bit code plus any flag out.
module prio_pick8
    import irq_pkg::*;
(
    input  logic [NREQ-1:0] i_vec,
    output logic [IDW-1:0]  o_code,
    output logic            o_any
);

    always_comb begin
        o_code = '0;
        o_any  = |i_vec;
        // Ascending scan so the highest-numbered set bit is the last to write.
        for (int i = 0; i < NREQ; i++) begin
            if (i_vec[i]) begin
                o_code = IDW'(i);
            end
        end
    end

endmodule

// File: rtl/irq_ctrl8.sv
// Latched, maskable 8-input interrupt controller offering the highest-priority
// unmasked request on a valid/ready handshake and holding it until end-of-interrupt.
module irq_ctrl8
    import irq_pkg::*;
#(
    parameter int EDGE_TRIG = 1
)
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic [NREQ-1:0] req,
    input  logic            mask_wr,
    input  logic [NREQ-1:0] mask_din,
    output logic            irq_valid,
    output logic [IDW-1:0]  irq_id,
    input  logic            irq_ready,
    input  logic            eoi,
    output logic            busy,
    output logic            none,
    output logic [NREQ-1:0] pending
);

    state_t          r_state;
    state_t          w_state_nx;
    logic [NREQ-1:0] r_req_q;
    logic [NREQ-1:0] r_pending;
    logic [NREQ-1:0] r_mask;
    logic [IDW-1:0]  r_irq_id;
    logic [IDW-1:0]  w_id_nx;
    logic            w_accept;
    logic [NREQ-1:0] w_rise;
    logic [NREQ-1:0] w_set_vec;
    logic [NREQ-1:0] w_clr_vec;
    logic [NREQ-1:0] w_cand;
    logic [IDW-1:0]  w_pick;
    logic            w_any;

    assign w_rise    = req & ~r_req_q;
    assign w_set_vec = (EDGE_TRIG != 0) ? w_rise : req;
    assign w_cand    = r_pending & ~r_mask;
    // Set is OR-ed in after the clear so a same-cycle re-request survives the accept.
    assign w_clr_vec = w_accept ? (NREQ'(1) << r_irq_id) : '0;

    prio_pick8 u_pick (
        .i_vec  (w_cand),
        .o_code (w_pick),
        .o_any  (w_any)
    );

    always_comb begin
        w_state_nx = r_state;
        w_id_nx    = r_irq_id;
        w_accept   = 1'b0;
        case (r_state)
            IDLE: begin
                if (en && w_any) begin
                    w_state_nx = OFFER;
                    w_id_nx    = w_pick;
                end
            end
            OFFER: begin
                if (irq_ready) begin
                    w_accept   = 1'b1;
                    w_state_nx = SERVICE;
                end else if (!en) begin
                    w_state_nx = IDLE;
                end
            end
            SERVICE: begin
                if (eoi) begin
                    w_state_nx = IDLE;
                end
            end
            default: w_state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_req_q   <= '0;
            r_pending <= '0;
            r_mask    <= '1;
            r_irq_id  <= '0;
        end else begin
            r_state   <= w_state_nx;
            r_req_q   <= req;
            r_pending <= (r_pending & ~w_clr_vec) | w_set_vec;
            r_irq_id  <= w_id_nx;
            if (mask_wr) begin
                r_mask <= mask_din;
            end
        end
    end

    assign irq_valid = (r_state == OFFER);
    assign busy      = (r_state == SERVICE);
    assign none      = (r_state == IDLE) && !w_any;
    assign irq_id    = r_irq_id;
    assign pending   = r_pending;

endmodule

// File: tb/tb_irq_ctrl8.sv
// Scenario bench for irq_ctrl8: edge-triggered instance plus a level-triggered one.
module tb_irq_ctrl8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en, mask_wr, irq_ready, eoi;
    logic [7:0] req, mask_din;
    logic       irq_valid, busy, none;
    logic [2:0] irq_id;
    logic [7:0] pending;

    logic       en2, mask_wr2, ready2, eoi2;
    logic [7:0] req2, mask_din2;
    logic       valid2, busy2, none2;
    logic [2:0] id2;
    logic [7:0] pending2;

    int n_tests = 0;
    int n_fail  = 0;
    logic [2:0] exp_q[$];

    always #5 clk = ~clk;

    irq_ctrl8 #(.EDGE_TRIG(1)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .req(req), .mask_wr(mask_wr),
        .mask_din(mask_din), .irq_valid(irq_valid), .irq_id(irq_id),
        .irq_ready(irq_ready), .eoi(eoi), .busy(busy), .none(none),
        .pending(pending)
    );

    irq_ctrl8 #(.EDGE_TRIG(0)) dut_lvl (
        .clk(clk), .rst_n(rst_n), .en(en2), .req(req2), .mask_wr(mask_wr2),
        .mask_din(mask_din2), .irq_valid(valid2), .irq_id(id2),
        .irq_ready(ready2), .eoi(eoi2), .busy(busy2), .none(none2),
        .pending(pending2)
    );

    // Accept monitor: the edge after this negedge accepts the offered id.
    always @(negedge clk) begin
        if (rst_n && irq_valid && irq_ready) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL accept_order: unexpected accept of id %0d, queue empty", irq_id);
            end else begin
                logic [2:0] e;
                e = exp_q.pop_front();
                if (irq_id !== e) begin
                    n_fail++;
                    $display("FAIL accept_order: got id %0d, expected %0d", irq_id, e);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b0; req = 8'h00; mask_wr = 1'b0; mask_din = 8'h00;
        irq_ready = 1'b0; eoi = 1'b0;
        en2 = 1'b0; req2 = 8'h00; mask_wr2 = 1'b0; mask_din2 = 8'h00;
        ready2 = 1'b0; eoi2 = 1'b0;
        step(); step();
        n_tests++;
        if ({irq_valid, busy, none, pending, irq_id} !== {1'b0, 1'b0, 1'b1, 8'h00, 3'd0}) begin
            n_fail++;
            $display("FAIL reset_values: valid=%b busy=%b none=%b pending=%h id=%0d, expected 0 0 1 00 0",
                     irq_valid, busy, none, pending, irq_id);
        end
        // Mask resets to all-ones: a request latches but is never offered.
        rst_n = 1'b1; en = 1'b1; req = 8'h01;
        step();
        req = 8'h00;
        step(); step();
        n_tests++;
        if ({pending, irq_valid, none} !== {8'h01, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL reset_mask: pending=%h valid=%b none=%b, expected 01 0 1",
                     pending, irq_valid, none);
        end
        rst_n = 1'b0; step();
        rst_n = 1'b1; step();
        n_tests++;
        if (pending !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_clear: pending=%h, expected 00", pending);
        end
    endtask

    task automatic test_single();
        mask_wr = 1'b1; mask_din = 8'h00; step(); mask_wr = 1'b0;
        req = 8'h20; exp_q.push_back(3'd5);
        step();
        req = 8'h00;
        n_tests++;
        if ({pending, irq_valid} !== {8'h20, 1'b0}) begin
            n_fail++;
            $display("FAIL single_latch: pending=%h valid=%b, expected 20 0", pending, irq_valid);
        end
        step();
        n_tests++;
        if ({irq_valid, irq_id, none} !== {1'b1, 3'd5, 1'b0}) begin
            n_fail++;
            $display("FAIL single_offer: valid=%b id=%0d none=%b, expected 1 5 0", irq_valid, irq_id, none);
        end
        irq_ready = 1'b1; step(); irq_ready = 1'b0;
        n_tests++;
        if ({busy, pending, irq_valid, irq_id} !== {1'b1, 8'h00, 1'b0, 3'd5}) begin
            n_fail++;
            $display("FAIL single_accept: busy=%b pending=%h valid=%b id=%0d, expected 1 00 0 5",
                     busy, pending, irq_valid, irq_id);
        end
        eoi = 1'b1; step(); eoi = 1'b0;
        n_tests++;
        if ({busy, none, irq_valid} !== {1'b0, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL single_eoi: busy=%b none=%b valid=%b, expected 0 1 0", busy, none, irq_valid);
        end
    endtask

    task automatic test_priority();
        req = 8'h44; exp_q.push_back(3'd6); exp_q.push_back(3'd2);
        irq_ready = 1'b1;
        step();
        req = 8'h00;
        step();
        n_tests++;
        if ({irq_valid, irq_id} !== {1'b1, 3'd6}) begin
            n_fail++;
            $display("FAIL prio_first: valid=%b id=%0d, expected 1 6", irq_valid, irq_id);
        end
        step(); step();
        n_tests++;
        if ({busy, pending, irq_valid} !== {1'b1, 8'h04, 1'b0}) begin
            n_fail++;
            $display("FAIL prio_no_preempt: busy=%b pending=%h valid=%b, expected 1 04 0",
                     busy, pending, irq_valid);
        end
        eoi = 1'b1; step(); eoi = 1'b0;
        n_tests++;
        if ({busy, irq_valid, none} !== {1'b0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL prio_eoi_idle: busy=%b valid=%b none=%b, expected 0 0 0", busy, irq_valid, none);
        end
        step();
        n_tests++;
        if ({irq_valid, irq_id} !== {1'b1, 3'd2}) begin
            n_fail++;
            $display("FAIL prio_second: valid=%b id=%0d, expected 1 2", irq_valid, irq_id);
        end
        step();
        irq_ready = 1'b0;
        n_tests++;
        if ({busy, pending} !== {1'b1, 8'h00}) begin
            n_fail++;
            $display("FAIL prio_second_accept: busy=%b pending=%h, expected 1 00", busy, pending);
        end
        eoi = 1'b1; step(); eoi = 1'b0;
    endtask

    task automatic test_freeze();
        req = 8'h08; exp_q.push_back(3'd3); exp_q.push_back(3'd7);
        step();
        req = 8'h00;
        step();
        req = 8'h80;
        step();
        req = 8'h00;
        n_tests++;
        if ({irq_valid, irq_id, pending} !== {1'b1, 3'd3, 8'h88}) begin
            n_fail++;
            $display("FAIL freeze_higher: valid=%b id=%0d pending=%h, expected 1 3 88",
                     irq_valid, irq_id, pending);
        end
        mask_wr = 1'b1; mask_din = 8'h08; step(); step();
        mask_wr = 1'b0;
        n_tests++;
        if ({irq_valid, irq_id} !== {1'b1, 3'd3}) begin
            n_fail++;
            $display("FAIL freeze_masked: valid=%b id=%0d, expected 1 3", irq_valid, irq_id);
        end
        mask_wr = 1'b1; mask_din = 8'h00; step(); mask_wr = 1'b0;
        irq_ready = 1'b1; step(); irq_ready = 1'b0;
        n_tests++;
        if ({busy, irq_id, pending} !== {1'b1, 3'd3, 8'h80}) begin
            n_fail++;
            $display("FAIL freeze_accept: busy=%b id=%0d pending=%h, expected 1 3 80", busy, irq_id, pending);
        end
        eoi = 1'b1; step(); eoi = 1'b0;
        step();
        n_tests++;
        if ({irq_valid, irq_id} !== {1'b1, 3'd7}) begin
            n_fail++;
            $display("FAIL freeze_next: valid=%b id=%0d, expected 1 7", irq_valid, irq_id);
        end
        irq_ready = 1'b1; step(); irq_ready = 1'b0;
        eoi = 1'b1; step(); eoi = 1'b0;
    endtask

    task automatic test_set_clear();
        mask_wr2 = 1'b1; mask_din2 = 8'h00; step(); mask_wr2 = 1'b0;
        en2 = 1'b1; req2 = 8'h10;
        step(); step();
        n_tests++;
        if ({valid2, id2} !== {1'b1, 3'd4}) begin
            n_fail++;
            $display("FAIL level_offer: valid=%b id=%0d, expected 1 4", valid2, id2);
        end
        ready2 = 1'b1; step(); ready2 = 1'b0;
        n_tests++;
        if ({busy2, pending2} !== {1'b1, 8'h10}) begin
            n_fail++;
            $display("FAIL set_wins: busy=%b pending=%h, expected 1 10", busy2, pending2);
        end
        req2 = 8'h00; en2 = 1'b0;
        eoi2 = 1'b1; step(); eoi2 = 1'b0;
        step();
        n_tests++;
        if ({busy2, valid2, pending2} !== {1'b0, 1'b0, 8'h10}) begin
            n_fail++;
            $display("FAIL level_disabled: busy=%b valid=%b pending=%h, expected 0 0 10",
                     busy2, valid2, pending2);
        end
    endtask

    task automatic test_en_drop();
        req = 8'h02; exp_q.push_back(3'd1);
        step();
        req = 8'h00;
        step();
        en = 1'b0;
        step();
        n_tests++;
        if ({irq_valid, pending, busy} !== {1'b0, 8'h02, 1'b0}) begin
            n_fail++;
            $display("FAIL en_drop: valid=%b pending=%h busy=%b, expected 0 02 0", irq_valid, pending, busy);
        end
        step();
        n_tests++;
        if (irq_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL en_hold_off: valid=%b, expected 0", irq_valid);
        end
        en = 1'b1;
        step();
        n_tests++;
        if ({irq_valid, irq_id} !== {1'b1, 3'd1}) begin
            n_fail++;
            $display("FAIL en_reoffer: valid=%b id=%0d, expected 1 1", irq_valid, irq_id);
        end
        irq_ready = 1'b1; step(); irq_ready = 1'b0;
        req = 8'h40; step(); req = 8'h00;
        n_tests++;
        if ({busy, pending} !== {1'b1, 8'h40}) begin
            n_fail++;
            $display("FAIL service_pending: busy=%b pending=%h, expected 1 40", busy, pending);
        end
        rst_n = 1'b0; step();
        n_tests++;
        if ({busy, irq_valid, pending, none} !== {1'b0, 1'b0, 8'h00, 1'b1}) begin
            n_fail++;
            $display("FAIL reset_in_service: busy=%b valid=%b pending=%h none=%b, expected 0 0 00 1",
                     busy, irq_valid, pending, none);
        end
        rst_n = 1'b1; step();
    endtask

    initial begin
        test_reset();
        test_single();
        test_priority();
        test_freeze();
        test_set_clear();
        test_en_drop();
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d expected accepts never seen, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
